// File: rtl/memshare_pkg.sv
// memshare_pkg: shared state encoding, default parameters and helpers for the memshare grant server
package memshare_pkg;
  localparam int DEF_GROUP_SIZE = 4;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_MEM_LAT = 2;
  typedef enum logic [1:0] {IDLE, SERVE, DRAIN} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/memshare_lsb_pick.sv
// memshare_lsb_pick: combinational lowest-set-bit picker with one-hot and index outputs
module memshare_lsb_pick
  import memshare_pkg::*;
#(
  parameter int N = DEF_GROUP_SIZE,
  parameter int IW = idx_w(DEF_GROUP_SIZE)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);
  assign onehot = req & (~req + N'(1));
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = IW'(i);
  end
endmodule

// File: rtl/memshare_grant_server.sv
// memshare_grant_server: serialises a batch of member reads onto one shared memory port and routes tagged responses back
module memshare_grant_server
  import memshare_pkg::*;
#(
  parameter int SHARED_GROUP_SIZE = DEF_GROUP_SIZE,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic                           sys_clk,
  input  logic                           rstn,
  input  logic                           rqst_vld,
  input  logic [SHARED_GROUP_SIZE-1:0]   rqst_mask,
  input  logic [SHARED_GROUP_SIZE*ADDR_W-1:0] rqst_addr,
  output logic                           rqst_rdy,
  output logic                           mem_rd_en,
  output logic [ADDR_W-1:0]              mem_rd_addr,
  input  logic [DATA_W-1:0]              mem_rd_data,
  output logic [SHARED_GROUP_SIZE-1:0]   rsp_vld,
  output logic [DATA_W-1:0]              rsp_data,
  output logic                           batch_done
);
  localparam int N = SHARED_GROUP_SIZE;
  localparam int IW = idx_w(SHARED_GROUP_SIZE);
  state_t state, state_nxt;
  logic [N-1:0] pend, pend_nxt, pick_oh;
  logic [IW-1:0] pick_idx;
  logic [N*ADDR_W-1:0] addr_q;
  logic [MEM_LAT-1:0][N-1:0] tag_pipe;
  logic [MEM_LAT-1:0] last_pipe;
  logic live, zero_pend, done_q, accept, issue;
  memshare_lsb_pick #(.N(N), .IW(IW)) u_pick (
    .req(pend),
    .onehot(pick_oh),
    .idx(pick_idx)
  );
  assign rqst_rdy = live && state == IDLE && !zero_pend;
  assign accept = rqst_vld && rqst_rdy;
  assign issue = state == SERVE && |pend;
  assign pend_nxt = pend & ~pick_oh;
  assign mem_rd_en = issue;
  assign mem_rd_addr = issue ? addr_q[int'(pick_idx)*ADDR_W +: ADDR_W] : '0;
  assign batch_done = done_q || zero_pend;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (accept && |rqst_mask) ? SERVE : IDLE;
      SERVE:   state_nxt = (pend_nxt == '0) ? DRAIN : SERVE;
      DRAIN:   state_nxt = done_q ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      live <= 1'b0;
      zero_pend <= 1'b0;
      pend <= '0;
      addr_q <= '0;
      tag_pipe <= '0;
      last_pipe <= '0;
      rsp_vld <= '0;
      rsp_data <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_nxt;
      live <= 1'b1;
      zero_pend <= accept && rqst_mask == '0;
      if (accept) begin
        pend <= rqst_mask;
        addr_q <= rqst_addr;
      end else if (issue) begin
        pend <= pend_nxt;
      end
      tag_pipe[0] <= issue ? pick_oh : '0;
      last_pipe[0] <= issue && pend_nxt == '0;
      for (int k = 1; k < MEM_LAT; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
        last_pipe[k] <= last_pipe[k-1];
      end
      rsp_vld <= tag_pipe[MEM_LAT-1];
      done_q <= last_pipe[MEM_LAT-1];
      if (|tag_pipe[MEM_LAT-1]) rsp_data <= mem_rd_data;
    end
  end
endmodule

// File: tb/tb_memshare_grant_server.sv
// tb_memshare_grant_server: table-driven batches with a response scoreboard and reset corner cases
module tb_memshare_grant_server;
  localparam int N = 4, AW = 8, DW = 16, LAT = 2;
  logic sys_clk = 1'b0;
  logic rstn = 1'b0;
  logic rqst_vld = 1'b0;
  logic [N-1:0] rqst_mask = '0;
  logic [N*AW-1:0] rqst_addr = '0;
  logic rqst_rdy, mem_rd_en, batch_done;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data, rsp_data;
  logic [N-1:0] rsp_vld;
  logic [DW-1:0] dpipe [LAT];
  typedef struct {logic [N-1:0] oh; logic [DW-1:0] data; logic last;} exp_t;
  typedef struct {logic [N-1:0] mask; logic [N*AW-1:0] addr; int reads; int done_lat;} vec_t;
  exp_t sb[$];
  vec_t vt[5];
  int n_cmp = 0, n_bad = 0;
  always #5 sys_clk = ~sys_clk;
  memshare_grant_server #(.SHARED_GROUP_SIZE(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .sys_clk(sys_clk), .rstn(rstn), .rqst_vld(rqst_vld), .rqst_mask(rqst_mask), .rqst_addr(rqst_addr),
    .rqst_rdy(rqst_rdy), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .batch_done(batch_done)
  );
  always @(posedge sys_clk) begin
    dpipe[0] <= mem_rd_en ? DW'(mem_rd_addr) + DW'(1) : 16'hdead;
    for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
  end
  assign mem_rd_data = dpipe[LAT-1];
  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction
  always @(negedge sys_clk) begin
    exp_t e;
    if (rstn && rsp_vld != '0) begin
      if (sb.size() == 0) check("rsp_unexpected", 32'(rsp_vld), 32'd0);
      else begin
        e = sb.pop_front();
        check("rsp_vld", 32'(rsp_vld), 32'(e.oh));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_done", 32'(batch_done), 32'(e.last));
      end
    end
  end
  task automatic check_zero(input string nm);
    check({nm, "_rdy"}, 32'(rqst_rdy), 32'd0);
    check({nm, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    check({nm, "_rd_addr"}, 32'(mem_rd_addr), 32'd0);
    check({nm, "_rsp_vld"}, 32'(rsp_vld), 32'd0);
    check({nm, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({nm, "_done"}, 32'(batch_done), 32'd0);
  endtask
  task automatic run_batch(input vec_t v, input bit hold, input int rst_at);
    int order[$];
    int nrd, dcyc, k, cnt;
    exp_t e;
    k = 0;
    while (!rqst_rdy && k < 20) begin
      @(negedge sys_clk);
      k++;
    end
    check("rdy_wait", 32'(rqst_rdy), 32'd1);
    rqst_vld = 1'b1;
    rqst_mask = v.mask;
    rqst_addr = v.addr;
    cnt = $countones(v.mask);
    for (int i = 0; i < N; i++)
      if (v.mask[i]) begin
        order.push_back(i);
        e.oh = N'(1) << i;
        e.data = DW'(v.addr[i*AW +: AW]) + DW'(1);
        e.last = order.size() == cnt;
        sb.push_back(e);
      end
    @(posedge sys_clk);
    #1;
    if (hold) begin
      rqst_mask = ~v.mask;
      rqst_addr = ~v.addr;
    end else rqst_vld = 1'b0;
    nrd = 0;
    dcyc = 0;
    for (k = 1; k <= 20 && dcyc == 0; k++) begin
      @(negedge sys_clk);
      if (k == rst_at) begin
        #2 rstn = 1'b0;
        #1 check_zero("rst_mid");
        sb.delete();
        rqst_vld = 1'b0;
        repeat (2) @(negedge sys_clk);
        rstn = 1'b1;
        for (int j = 0; j < 8; j++) begin
          @(negedge sys_clk);
          check("post_rst_done", 32'(batch_done), 32'd0);
        end
        return;
      end
      if (mem_rd_en) begin
        check("rd_slot", 32'(k), 32'(nrd + 1));
        if (nrd < order.size()) check("rd_addr", 32'(mem_rd_addr), 32'(v.addr[order[nrd]*AW +: AW]));
        else check("rd_extra", 32'(mem_rd_en), 32'd0);
        nrd++;
      end
      if (batch_done) begin
        dcyc = k;
        check("rdy_busy", 32'(rqst_rdy), 32'd0);
      end
    end
    check("done_lat", 32'(dcyc), 32'(v.done_lat));
    check("reads", 32'(nrd), 32'(v.reads));
    @(negedge sys_clk);
    check("rdy_back", 32'(rqst_rdy), 32'd1);
    check("done_pulse", 32'(batch_done), 32'd0);
    if (hold) rqst_vld = 1'b0;
  endtask
  initial begin
    vec_t r;
    vt[0] = '{mask: 4'b1011, addr: 32'h4433_2211, reads: 3, done_lat: 6};
    vt[1] = '{mask: 4'b0000, addr: 32'h5555_5555, reads: 0, done_lat: 1};
    vt[2] = '{mask: 4'b1111, addr: 32'h4030_2010, reads: 4, done_lat: 7};
    vt[3] = '{mask: 4'b0001, addr: 32'h0000_00a5, reads: 1, done_lat: 4};
    vt[4] = '{mask: 4'b1000, addr: 32'hfe00_0000, reads: 1, done_lat: 4};
    #12 check_zero("rst");
    @(negedge sys_clk);
    rstn = 1'b1;
    @(negedge sys_clk);
    check("rdy_after_rst", 32'(rqst_rdy), 32'd1);
    for (int i = 0; i < 5; i++) run_batch(vt[i], 1'b0, 0);
    run_batch('{mask: 4'b0101, addr: 32'h7766_5544, reads: 2, done_lat: 5}, 1'b1, 0);
    run_batch('{mask: 4'b0110, addr: 32'h0099_8800, reads: 2, done_lat: 5}, 1'b0, 4);
    run_batch('{mask: 4'b0001, addr: 32'h0000_0033, reads: 1, done_lat: 4}, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      r.mask = N'($urandom_range(0, 15));
      r.addr = $urandom;
      r.reads = $countones(r.mask);
      r.done_lat = r.mask == '0 ? 1 : r.reads + LAT + 1;
      run_batch(r, i[0], 0);
    end
    repeat (4) @(negedge sys_clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/memshare_grant_server.md
MEMSHARE_GRANT_SERVER -- requirements
Module: memshare_grant_server

Interface
REQ-001 SHALL have parameter SHARED_GROUP_SIZE, default 4: members sharing one memory port.
REQ-002 SHALL have parameter ADDR_W, default 8: shared-memory address width.
REQ-003 SHALL have parameter DATA_W, default 16: shared-memory data width.
REQ-004 SHALL have parameter MEM_LAT, default 2, legal range 1..4: memory read latency in cycles.
REQ-005 SHALL have port sys_clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port rqst_vld, input, 1: a request batch is presented.
REQ-008 SHALL have port rqst_mask, input, SHARED_GROUP_SIZE: members requesting in this batch.
REQ-009 SHALL have port rqst_addr, input, SHARED_GROUP_SIZE*ADDR_W: member i address in bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port rqst_rdy, output, 1: block can accept a batch.
REQ-011 SHALL have port mem_rd_en, output, 1: shared-memory read strobe.
REQ-012 SHALL have port mem_rd_addr, output, ADDR_W: shared-memory read address.
REQ-013 SHALL have port mem_rd_data, input, DATA_W: read data, valid exactly MEM_LAT cycles after the mem_rd_en cycle.
REQ-014 SHALL have port rsp_vld, output, SHARED_GROUP_SIZE: one-hot, identifies the member receiving rsp_data.
REQ-015 SHALL have port rsp_data, output, DATA_W: returned read data.
REQ-016 SHALL have port batch_done, output, 1: single-cycle pulse on completion of a batch.

Function
REQ-017 SHALL accept a batch on any edge where rqst_vld && rqst_rdy, capturing rqst_mask and all of rqst_addr.
REQ-018 SHALL drive rqst_rdy high only in state IDLE; no batch is accepted in any other state.
REQ-019 SHALL implement states IDLE, SERVE and DRAIN.
- IDLE -> SERVE on accepting a non-zero mask.
- SERVE -> DRAIN on the cycle the last pending member issues.
- DRAIN -> IDLE on the cycle the last response is delivered.
REQ-020 SHALL, in SERVE, issue exactly one read per cycle to the lowest-index pending member, with mem_rd_en=1 and mem_rd_addr = that member's captured address, then clear its pending bit.
REQ-021 SHALL issue the first read in the cycle immediately after acceptance, with no idle cycles between issues.
REQ-022 SHALL carry a member tag through a MEM_LAT-deep shift pipeline and register mem_rd_data, so that rsp_vld/rsp_data for a read appear MEM_LAT+1 cycles after its mem_rd_en cycle.
REQ-023 SHALL pulse batch_done in the same cycle as the final rsp_vld of a batch.
REQ-024 SHALL, for a zero-mask batch, stay in IDLE, issue no read, pulse batch_done on the next cycle, and hold rqst_rdy low during that cycle.
REQ-025 SHALL hold rsp_vld at zero and mem_rd_en low in every cycle with no valid output; mem_rd_addr and rsp_data are don't-care in those cycles.
REQ-026 SHALL hold the captured mask and addresses stable for the whole batch, regardless of changes on rqst_* inputs.

Reset
REQ-027 SHALL, on rstn low (asynchronous), force state IDLE, clear pending mask and tag pipeline, and set rqst_rdy=0, mem_rd_en=0, rsp_vld=0, batch_done=0, mem_rd_addr=0, rsp_data=0.
REQ-028 SHALL drive rqst_rdy=1 from the first edge after rstn deasserts.
REQ-029 SHALL discard in-flight reads on reset mid-batch: no rsp_vld and no batch_done for that batch after reset.

Structure
REQ-030 SHALL take its state encoding and default parameter constants from shared package memshare_pkg.
REQ-031 SHALL use one sub-module, memshare_lsb_pick: a combinational lowest-set-bit one-hot picker plus index output.

Verification
REQ-032 Mask 4'b1011, MEM_LAT=2, accepted at edge T -> mem_rd_en at T+1, T+2, T+3 for members 0, 1, 3; rsp_vld 0001@T+4, 0010@T+5, 1000@T+6; batch_done@T+6; rqst_rdy=1@T+7.
REQ-033 Mask 4'b0000 -> no mem_rd_en; batch_done one cycle after acceptance; rqst_rdy low for exactly that cycle.
REQ-034 Mask 4'b1111 with addresses 0x10, 0x20, 0x30, 0x40, memory returning addr+1 -> rsp_data 0x11, 0x21, 0x31, 0x41 in member order.
REQ-035 rqst_vld held high and rqst_mask changed during SERVE -> new batch ignored until rqst_rdy returns; the first batch completes unchanged.
REQ-036 rstn pulsed low during DRAIN of mask 4'b0110 -> all outputs zero immediately; no later rsp_vld or batch_done; next batch 4'b0001 completes normally.
